// File: rtl/sobel_datapath.sv
// sobel_datapath: row-word capture, sliding 3x3 window and Sobel magnitude packed four pixels per word.
// Define SOBEL_THRESH_EN to binarise each pixel against THRESH.
module sobel_datapath #(
  parameter logic [7:0] THRESH = 8'd64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  input  logic        prev_row_load,
  input  logic        curr_row_load,
  input  logic        next_row_load,
  input  logic        shift_en,
  input  logic        row_clr,
  output logic [31:0] dat_o
);
  logic [31:0] prev_word, curr_word, next_word;
  logic [23:0] col_l, col_c, col_r;
  logic signed [10:0] gx, gy;
  logic [10:0] abs_sum;
  logic [7:0] mag, pix;
  function automatic logic signed [10:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
  endfunction
  // columns are packed {top, mid, bottom}
  assign gx = wsum(col_r[23:16], col_r[15:8], col_r[7:0]) - wsum(col_l[23:16], col_l[15:8], col_l[7:0]);
  assign gy = wsum(col_l[7:0], col_c[7:0], col_r[7:0]) - wsum(col_l[23:16], col_c[23:16], col_r[23:16]);
  assign abs_sum = (gx[10] ? -gx : gx) + (gy[10] ? -gy : gy);
  assign mag = 8'(abs_sum >> 3);
`ifdef SOBEL_THRESH_EN
  assign pix = (mag >= THRESH) ? 8'hFF : 8'h00;
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign pix = mag;
`endif
  always_ff @(posedge clk_i)
    if (rst_i) begin
      prev_word <= '0;
      curr_word <= '0;
      next_word <= '0;
      col_l <= '0;
      col_c <= '0;
      col_r <= '0;
      dat_o <= '0;
    end else begin
      prev_word <= (prev_row_load && ack_i) ? dat_i : shift_en ? prev_word << 8 : prev_word;
      curr_word <= (curr_row_load && ack_i) ? dat_i : shift_en ? curr_word << 8 : curr_word;
      next_word <= (next_row_load && ack_i) ? dat_i : shift_en ? next_word << 8 : next_word;
      if (row_clr) begin
        col_l <= '0;
        col_c <= '0;
        col_r <= '0;
        dat_o <= '0;
      end else if (shift_en) begin
        col_l <= col_c;
        col_c <= col_r;
        col_r <= {prev_word[31:24], curr_word[31:24], next_word[31:24]};
        dat_o <= {dat_o[23:0], pix};
      end
    end
endmodule

// File: tb/tb_sobel_datapath.sv
// tb_sobel_datapath: table of row blocks with hand-computed result words, plus directed corner sequences.
module tb_sobel_datapath;
  localparam logic [7:0] TH = 8'd100;
  logic clk_i = 0, rst_i = 1, ack_i = 0, prev_row_load = 0, curr_row_load = 0, next_row_load = 0;
  logic shift_en = 0, row_clr = 0;
  logic [31:0] dat_i = 0, dat_o;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    bit clr;
    bit ld;
    logic [31:0] p, c, n, exp;
  } vec_t;
  vec_t tbl[14];
  sobel_datapath #(.THRESH(TH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ack_i(ack_i), .dat_i(dat_i),
    .prev_row_load(prev_row_load), .curr_row_load(curr_row_load), .next_row_load(next_row_load),
    .shift_en(shift_en), .row_clr(row_clr), .dat_o(dat_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  function automatic logic [31:0] thr(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef SOBEL_THRESH_EN
    for (int i = 0; i < 4; i++) r[8*i +: 8] = (w[8*i +: 8] >= TH) ? 8'hFF : 8'h00;
`endif
    return r;
  endfunction
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle();
    {ack_i, prev_row_load, curr_row_load, next_row_load, shift_en, row_clr} = '0;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic load(input int which, input logic [31:0] d, input bit clr);
    ack_i = 1;
    dat_i = d;
    row_clr = clr;
    prev_row_load = (which == 0);
    curr_row_load = (which == 1);
    next_row_load = (which == 2);
    cyc();
    idle();
  endtask
  task automatic shifts(input int n);
    shift_en = 1;
    for (int i = 0; i < n; i++) cyc();
    shift_en = 0;
  endtask
  initial begin
    tbl[0]  = '{1, 1, 32'h80808080, 32'h80808080, 32'h80808080, 32'h00404000};
    tbl[1]  = '{0, 1, 32'h80808080, 32'h80808080, 32'h80808080, 32'h00000000};
    tbl[2]  = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h00404000};
    tbl[3]  = '{1, 1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h003F7F7F};
    tbl[4]  = '{0, 1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h7F7F7F7F};
    tbl[5]  = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h7F7F3F00};
    tbl[6]  = '{1, 1, 32'h000000FF, 32'h000000FF, 32'h000000FF, 32'h00000000};
    tbl[7]  = '{0, 1, 32'h000000FF, 32'h000000FF, 32'h000000FF, 32'h7F007F00};
    tbl[8]  = '{0, 1, 32'h000000FF, 32'h000000FF, 32'h000000FF, 32'h7F007F00};
    tbl[9]  = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h7F007F00};
    tbl[10] = '{1, 1, 32'h00000000, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00007FBF};
    tbl[11] = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h7FBF7F00};
    tbl[12] = '{1, 1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h003F7F7F};
    tbl[13] = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h7F7F3F00};
    cyc();
    cyc();
    rst_i = 0;
    chk("reset dat_o", dat_o, 32'h0);
    chk("reset prev_word", dut.prev_word, 32'h0);
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].ld) begin
        load(0, tbl[i].p, tbl[i].clr);
        load(1, tbl[i].c, 0);
        load(2, tbl[i].n, 0);
      end
      shifts(4);
      chk($sformatf("vec%0d", i), dat_o, thr(tbl[i].exp));
    end
    // reset in the middle of a horizontal-edge row
    load(0, 32'h0, 1);
    load(1, 32'h0, 0);
    load(2, 32'hFFFFFFFF, 0);
    shifts(2);
    chk("midrow dat_o", dat_o, thr(32'h0000003F));
    rst_i = 1;
    cyc();
    rst_i = 0;
    chk("rst dat_o", dat_o, 32'h0);
    chk("rst next_word", dut.next_word, 32'h0);
    chk("rst col_c", {8'h0, dut.col_c}, 32'h0);
    chk("rst col_r", {8'h0, dut.col_r}, 32'h0);
    load(1, 32'h12345678, 0);
    chk("post-rst load", dut.curr_word, 32'h12345678);
    // load without ack is ignored
    next_row_load = 1;
    dat_i = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("noack%0d", i), dut.next_word, 32'h0);
    end
    ack_i = 1;
    cyc();
    idle();
    chk("ack load", dut.next_word, 32'h12345678);
    // load and shift together: word takes dat_i, window takes old MSB
    next_row_load = 1;
    ack_i = 1;
    dat_i = 32'hAABBCCDD;
    shift_en = 1;
    cyc();
    idle();
    chk("ldsh next_word", dut.next_word, 32'hAABBCCDD);
    chk("ldsh col_r", {8'h0, dut.col_r}, 32'h00001212);
    chk("ldsh curr_word", dut.curr_word, 32'h34567800);
    shifts(1);
    chk("small mag", dat_o, thr(32'h00000009));
    cyc();
    cyc();
    chk("hold", dat_o, thr(32'h00000009));
    // row_clr beats shift; words still shift or load
    row_clr = 1;
    shift_en = 1;
    prev_row_load = 1;
    ack_i = 1;
    dat_i = 32'h55555555;
    cyc();
    idle();
    chk("clr dat_o", dat_o, 32'h0);
    chk("clr col_c", {8'h0, dut.col_c}, 32'h0);
    chk("clr col_r", {8'h0, dut.col_r}, 32'h0);
    chk("clr prev_word", dut.prev_word, 32'h55555555);
    chk("clr next_word", dut.next_word, 32'hCCDD0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
